// File: rtl/avg_threshold_monitor.sv
// avg_threshold_monitor
//   Hysteresis alarm detector with debounce, fed by the moving-average filter.
//   It also tracks the running peak max/min since the last clear and counts
//   alarm events.
//
//   Sample handshake: a sample is taken on a rising clk edge when
//   enable && din_valid. There is no back-pressure; every strobe is consumed.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : block enable; when low, all state holds and pulses are 0
//   din_valid    : one-cycle sample strobe
//   din          : signed filtered sample
//   thr_high     : signed upper threshold (alarm raise, strict >)
//   thr_low      : signed lower threshold (alarm clear, strict <)
//   debounce     : consecutive qualifying samples required (0 acts as 1)
//   clear_peak   : restart peak tracking
//   alarm        : alarm level (ALARM or PEND_LOW)
//   alarm_rise   : one-cycle pulse on alarm 0->1
//   alarm_fall   : one-cycle pulse on alarm 1->0
//   peak_max     : signed maximum since the last clear
//   peak_min     : signed minimum since the last clear
//   peak_valid   : at least one sample taken since reset/clear
//   event_cnt    : saturating count of alarm rises
//   config_err   : registered thr_low > thr_high flag; freezes the FSM
//   dbg_state    : current FSM state (debug observation)
module avg_threshold_monitor #(
  parameter int DEB_W = 4,
  parameter int EVT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                din_valid,
  input  logic signed [15:0]  din,
  input  logic signed [15:0]  thr_high,
  input  logic signed [15:0]  thr_low,
  input  logic [DEB_W-1:0]    debounce,
  input  logic                clear_peak,
  output logic                alarm,
  output logic                alarm_rise,
  output logic                alarm_fall,
  output logic signed [15:0]  peak_max,
  output logic signed [15:0]  peak_min,
  output logic                peak_valid,
  output logic [EVT_W-1:0]    event_cnt,
  output logic                config_err,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_NORMAL    = 2'd0,
    S_PEND_HIGH = 2'd1,
    S_ALARM     = 2'd2,
    S_PEND_LOW  = 2'd3
  } state_e;

  localparam logic signed [15:0] PEAK_MAX_RST = 16'sh8000;
  localparam logic signed [15:0] PEAK_MIN_RST = 16'sh7FFF;

  state_e                    state_q, state_d;
  logic [DEB_W-1:0]          cnt_q, cnt_d;
  logic                      rise_q, rise_d;
  logic                      fall_q, fall_d;
  logic                      cfg_err_q;
  logic signed [15:0]        max_q, max_d;
  logic signed [15:0]        min_q, min_d;
  logic                      pvalid_q, pvalid_d;
  logic [EVT_W-1:0]          evt_q, evt_d;

  logic                      accept;
  logic                      advance;
  logic                      above;
  logic                      below;
  logic [DEB_W:0]            k_val;
  logic [DEB_W:0]            cnt_inc;
  logic                      k_is_one;
  logic                      run_done;

  assign accept   = enable & din_valid;
  // A misconfigured threshold pair freezes the detector but not peak tracking.
  assign advance  = accept & ~cfg_err_q;
  assign above    = (din > thr_high);
  assign below    = (din < thr_low);

  // One extra bit so counter+1 never wraps when compared against K.
  assign k_val    = (debounce == '0) ? (DEB_W+1)'(1) : {1'b0, debounce};
  assign cnt_inc  = {1'b0, cnt_q} + (DEB_W+1)'(1);
  assign k_is_one = (k_val == (DEB_W+1)'(1));
  // >= rather than == so a debounce lowered mid-run completes on the next
  // qualifying sample.
  assign run_done = (cnt_inc >= k_val);

  // Next-state logic for the hysteresis FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (advance) begin
      unique case (state_q)
        S_NORMAL: begin
          if (above) begin
            cnt_d = DEB_W'(1);
            if (k_is_one) begin
              state_d = S_ALARM;
              rise_d  = 1'b1;
            end else begin
              state_d = S_PEND_HIGH;
            end
          end
        end
        S_PEND_HIGH: begin
          if (above) begin
            if (run_done) begin
              state_d = S_ALARM;
              cnt_d   = '0;
              rise_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc[DEB_W-1:0];
            end
          end else begin
            state_d = S_NORMAL;
            cnt_d   = '0;
          end
        end
        S_ALARM: begin
          if (below) begin
            cnt_d = DEB_W'(1);
            if (k_is_one) begin
              state_d = S_NORMAL;
              fall_d  = 1'b1;
            end else begin
              state_d = S_PEND_LOW;
            end
          end
        end
        S_PEND_LOW: begin
          if (below) begin
            if (run_done) begin
              state_d = S_NORMAL;
              cnt_d   = '0;
              fall_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc[DEB_W-1:0];
            end
          end else begin
            state_d = S_ALARM;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_NORMAL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Peak tracking and event counter next values.
  always_comb begin
    max_d    = max_q;
    min_d    = min_q;
    pvalid_d = pvalid_q;
    evt_d    = evt_q;
    if (accept) begin
      if (clear_peak) begin
        // Clear and sample together: tracking restarts at this sample.
        max_d = din;
        min_d = din;
      end else begin
        if (din > max_q) max_d = din;
        if (din < min_q) min_d = din;
      end
      pvalid_d = 1'b1;
    end else if (clear_peak) begin
      max_d    = PEAK_MAX_RST;
      min_d    = PEAK_MIN_RST;
      pvalid_d = 1'b0;
    end
    if (rise_d && (evt_q != '1)) begin
      evt_d = evt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_NORMAL;
      cnt_q     <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      max_q     <= PEAK_MAX_RST;
      min_q     <= PEAK_MIN_RST;
      pvalid_q  <= 1'b0;
      evt_q     <= '0;
    end else if (enable) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      cfg_err_q <= (thr_low > thr_high);
      max_q     <= max_d;
      min_q     <= min_d;
      pvalid_q  <= pvalid_d;
      evt_q     <= evt_d;
    end else begin
      // Disabled: everything holds except the pulses, which drop.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end
  end

  assign alarm      = (state_q == S_ALARM) || (state_q == S_PEND_LOW);
  assign alarm_rise = rise_q;
  assign alarm_fall = fall_q;
  assign peak_max   = max_q;
  assign peak_min   = min_q;
  assign peak_valid = pvalid_q;
  assign event_cnt  = evt_q;
  assign config_err = cfg_err_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/avg_threshold_monitor.md
Name: avg_threshold_monitor

Overview:
- Downstream consumer of the moving-average filter: takes the filtered signed sample and its valid pulse and runs a hysteresis alarm detector with debounce.
- Also tracks the running peak max/min since the last clear and counts alarm events.
- Feeds the status/interrupt logic; purely synchronous, one sample evaluated per valid pulse.

Parameters:
- DEB_W, 4, width of debounce setting and internal consecutive-sample counter.
- EVT_W, 8, width of saturating alarm-event counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  block enable; when low, all state holds and pulses are 0
- din_valid  in  1  one-cycle sample strobe (filter output pulse)
- din  in  16  signed filtered sample (filter dout)
- thr_high  in  16  signed upper threshold, static while enabled
- thr_low  in  16  signed lower threshold, static while enabled
- debounce  in  DEB_W  required consecutive qualifying samples; 0 treated as 1
- clear_peak  in  1  one-cycle request to restart peak tracking
- alarm  out  1  registered alarm level
- alarm_rise  out  1  one-cycle pulse on alarm 0->1
- alarm_fall  out  1  one-cycle pulse on alarm 1->0
- peak_max  out  16  signed maximum since last clear
- peak_min  out  16  signed minimum since last clear
- peak_valid  out  1  high once at least one sample has been taken since reset/clear
- event_cnt  out  EVT_W  count of alarm_rise events, saturating
- config_err  out  1  registered flag, thr_low > thr_high

Behaviour:
- Reset (async, rst_n low): alarm=0, alarm_rise=0, alarm_fall=0, peak_max=16'sh8000, peak_min=16'sh7FFF, peak_valid=0, event_cnt=0, config_err=0, FSM=NORMAL, counter=0.
- A sample is accepted on a rising clk edge with enable=1 and din_valid=1. Cycles without an accepted sample never change FSM state or counter.
- Define K = (debounce==0) ? 1 : debounce. Define above = din > thr_high and below = din < thr_low. Both comparisons are signed and strict.
- FSM states: NORMAL, PEND_HIGH, ALARM, PEND_LOW. Each transition below happens on an accepted sample.
  - NORMAL, sample above: counter=1. Go to ALARM if K==1, else PEND_HIGH.
  - PEND_HIGH, sample above: counter+1. Go to ALARM when counter+1==K.
  - PEND_HIGH, sample not above: go to NORMAL, counter=0.
  - ALARM, sample below: counter=1. Go to NORMAL if K==1, else PEND_LOW.
  - PEND_LOW, sample below: counter+1. Go to NORMAL when counter+1==K.
  - PEND_LOW, sample not below: go to ALARM, counter=0.
- alarm is 1 in ALARM and PEND_LOW, 0 in NORMAL and PEND_HIGH. Latency: alarm changes on the same edge that accepts the K-th qualifying sample.
- alarm_rise and alarm_fall assert on that same edge and clear on the next edge. They are never both high.
- config_err is registered every enabled cycle. While config_err=1, samples do not advance the FSM, but peak tracking still runs.
- Peak tracking:
  - On an accepted sample: peak_max=max(peak_max,din), peak_min=min(peak_min,din), peak_valid=1.
  - clear_peak with no sample (enable=1): peak_max/peak_min return to reset values, peak_valid=0.
  - clear_peak together with an accepted sample: both peaks load din and peak_valid=1.
- event_cnt increments on each alarm_rise and saturates at 2^EVT_W-1. It is cleared only by reset.
- If debounce changes mid-count, the new K applies from the next sample. If counter already ≥ new K, the next qualifying sample completes the transition.
- enable low: the FSM, counter, peaks and event_cnt hold; alarm holds its level; alarm_rise, alarm_fall and clear_peak are ignored/0.
- Reset asserted mid-PEND state or mid-pulse: all outputs immediately take their reset values with no completion pulse.

Test Plan:
- thr_high=100, thr_low=50, debounce=3; samples 120,130,140 -> alarm rises on the 3rd accepted sample, alarm_rise is one cycle wide, event_cnt=1.
- From ALARM, samples 40,60,40,40,40 (debounce=3) -> 60 returns the FSM to ALARM with no fall pulse; alarm_fall fires on the 3rd consecutive 40 and alarm=0.
- debounce=0, sample 101 -> alarm=1 on that edge. Then sample 49 -> alarm=0 on that edge. Samples equal to 100 or 50 cause no change (strict compare).
- Samples -300, 500, 20, then clear_peak together with sample 7 -> peak_max=500 and peak_min=-300 before the clear; both equal 7 after it, with peak_valid=1 throughout.
- thr_low=200, thr_high=100 -> config_err=1, samples of 300 never raise alarm, peaks still update. Restore thresholds -> normal operation resumes.
- Reset asserted in PEND_HIGH with counter=2 -> all outputs return to reset values asynchronously. After release, a fresh run of K samples is required to raise alarm.
